// File: rtl/rr_sched16.sv
// ----------------------------------------------------------------------------
// rr_sched16 -- 16-requester round-robin scheduler with hold-time limit.
//
// A single shared resource is granted to one requester at a time. The winner
// is the first asserted request bit found scanning upward from the previous
// winner plus one, wrapping 15 -> 0. A grant ends at the first edge where the
// holder signals done, the holder drops its request, or the grant has been
// held for HOLD_MAX cycles. Each grant is followed by one GAP cycle and one
// IDLE cycle before the next grant can be issued.
//
// Parameters
//   HOLD_MAX   maximum cycles a grant is held before forced release (1..255)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        request vector, bit i = requester i wants the resource
//   done       holder releases the resource (only looked at while granting)
//   grant_idx  index of the granted requester (qualify with grant_vld)
//   grant_vld  high while grant_idx denotes a live grant
//   grant_oh   one-hot grant, all zero when grant_vld is low
//   timeout    one-cycle pulse after a grant is revoked by the hold limit
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module rr_sched16 #(
    parameter int HOLD_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  grant_idx,
    output logic        grant_vld,
    output logic [15:0] grant_oh,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_MAX_C  = 8'(HOLD_MAX);
    localparam logic [7:0] HOLD_LAST_C = 8'(HOLD_MAX - 1);

    logic [1:0]  state_q,    state_d;
    logic [3:0]  idx_q,      idx_d;
    logic        vld_q,      vld_d;
    logic [15:0] oh_q,       oh_d;
    logic        timeout_q,  timeout_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  last_q,     last_d;

    logic [3:0]  winner;
    logic [3:0]  cand;
    logic        expired;
    logic        owner_req;

    assign expired   = (hold_cnt_q == HOLD_LAST_C);
    assign owner_req = req[idx_q];

    // Scan from the farthest candidate back to the nearest so the closest
    // requester after last_q is the one left in winner. The 4-bit add wraps
    // naturally; offset 16 truncates to 0 and lands on last_q itself, which
    // lets a lone requester win again.
    always_comb begin
        winner = last_q;
        cand   = '0;
        for (int k = 16; k >= 1; k--) begin
            cand = last_q + 4'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        vld_d      = vld_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_GRANT;
                    idx_d      = winner;
                    vld_d      = 1'b1;
                    hold_cnt_d = '0;
                    last_d     = winner;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = (hold_cnt_q == HOLD_MAX_C) ? hold_cnt_q : hold_cnt_q + 8'd1;
                if (done || !owner_req || expired) begin
                    state_d   = ST_GAP;
                    vld_d     = 1'b0;
                    // done and a dropped request both count as voluntary
                    // release, so they mask the timeout indication.
                    timeout_d = expired && !done && owner_req;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase

        // One-hot built from the next-state values so it lines up with
        // grant_idx/grant_vld in the same register stage.
        oh_d = vld_d ? (16'd1 << idx_d) : '0;
    end

    // NOTE: reset is asynchronous and active-low, so a grant is revoked the
    // moment rst_n falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            vld_q      <= 1'b0;
            oh_q       <= '0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= 4'd15;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            idx_q      <= idx_d;
            vld_q      <= vld_d;
            oh_q       <= oh_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign grant_idx = idx_q;
    assign grant_vld = vld_q;
    assign grant_oh  = oh_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sched16.sv
// ----------------------------------------------------------------------------
// tb_rr_sched16 -- self-checking bench for rr_sched16 (HOLD_MAX = 4).
//
// A transaction-level reference model (grant owner, cycles held, idle cycles
// still owed, round-robin pointer) predicts the outputs; a compare process
// checks them on every falling edge. Directed sequences pin the model with
// hand-computed values, then randomized request/done traffic runs.
// ----------------------------------------------------------------------------
module tb_rr_sched16;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [3:0]  grant_idx;
    logic        grant_vld;
    logic [15:0] grant_oh;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    rr_sched16 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .grant_oh  (grant_oh),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_len counts cycles the current grant has been visible; m_wait counts
    // the idle cycles still owed after a release before a new grant is legal.
    logic       m_vld;
    logic [3:0] m_idx;
    int         m_last;
    int         m_len;
    int         m_wait;
    logic       m_timeout;

    always @(posedge clk or negedge rst_n) begin : ref_model
        int w;
        bit over;
        bit rel;
        if (!rst_n) begin
            m_vld     <= 1'b0;
            m_idx     <= 4'd0;
            m_last    <= 15;
            m_len     <= 0;
            m_wait    <= 0;
            m_timeout <= 1'b0;
        end else begin
            m_timeout <= 1'b0;
            if (m_vld) begin
                over = (m_len == HOLD);
                rel  = done || !req[m_idx] || over;
                if (rel) begin
                    m_vld     <= 1'b0;
                    m_wait    <= 1;
                    m_timeout <= over && !done && req[m_idx];
                end else begin
                    m_len <= m_len + 1;
                end
            end else if (m_wait > 0) begin
                m_wait <= m_wait - 1;
            end else if (req != 16'h0) begin
                w = -1;
                for (int k = 1; k <= 16; k++) begin
                    if (w < 0 && req[(m_last + k) % 16]) w = (m_last + k) % 16;
                end
                m_vld  <= 1'b1;
                m_idx  <= w[3:0];
                m_last <= w;
                m_len  <= 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        check("idx",     {28'h0, grant_idx}, {28'h0, m_idx});
        check("vld",     {31'h0, grant_vld}, {31'h0, m_vld});
        check("oh",      {16'h0, grant_oh},  m_vld ? (32'h1 << m_idx) : 32'h0);
        check("timeout", {31'h0, timeout},   {31'h0, m_timeout});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req   = 16'h0;
        done  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int lows);
        lows = 0;
        while (!grant_vld && lows < 8) begin
            lows++;
            tick();
        end
        check("grant_seen", {31'h0, grant_vld}, 32'h1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int lows;
        int cnt;
        logic [15:0] r;

        rst_n = 1'b0;
        req   = 16'h0;
        done  = 1'b0;
        tick();
        check("rst_vld", {31'h0, grant_vld}, 32'h0);
        check("rst_idx", {28'h0, grant_idx}, 32'h0);
        check("rst_oh",  {16'h0, grant_oh},  32'h0);
        check("rst_to",  {31'h0, timeout},   32'h0);
        rst_n = 1'b1;
        tick();

        // single requester, done release
        req = 16'h0001;
        tick();
        check("t1_idx", {28'h0, grant_idx}, 32'h0);
        check("t1_vld", {31'h0, grant_vld}, 32'h1);
        check("t1_oh",  {16'h0, grant_oh},  32'h0001);
        pulse_done();
        check("t1_rel_vld", {31'h0, grant_vld}, 32'h0);
        check("t1_rel_to",  {31'h0, timeout},   32'h0);
        check("t1_rel_oh",  {16'h0, grant_oh},  32'h0);
        check("t1_idx_hold", {28'h0, grant_idx}, 32'h0);

        // full rotation, two idle cycles between grants
        reset_dut();
        req = 16'hFFFF;
        for (int g = 0; g < 17; g++) begin
            wait_grant(lows);
            check("rr_idx", {28'h0, grant_idx}, g % 16);
            if (g > 0) check("rr_gap", lows, 2);
            pulse_done();
        end

        // hold limit on requester 8
        reset_dut();
        req = 16'h0100;
        tick();
        check("hl_idx", {28'h0, grant_idx}, 32'h8);
        cnt = 0;
        while (grant_vld && cnt < 20) begin
            cnt++;
            tick();
        end
        check("hl_len", cnt, 4);
        check("hl_to",  {31'h0, timeout}, 32'h1);
        tick();
        check("hl_to_once", {31'h0, timeout}, 32'h0);
        check("hl_gap_vld", {31'h0, grant_vld}, 32'h0);

        // done on the expiry edge wins over timeout
        reset_dut();
        req = 16'h0100;
        repeat (4) tick();
        check("dx_vld_before", {31'h0, grant_vld}, 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("dx_vld", {31'h0, grant_vld}, 32'h0);
        check("dx_to",  {31'h0, timeout},   32'h0);

        // wrap 15 -> 0 -> 15
        reset_dut();
        req = 16'h8000;
        tick();
        check("wr_15", {28'h0, grant_idx}, 32'hF);
        pulse_done();
        req = 16'h8001;
        wait_grant(lows);
        check("wr_0", {28'h0, grant_idx}, 32'h0);
        pulse_done();
        wait_grant(lows);
        check("wr_15b", {28'h0, grant_idx}, 32'hF);
        pulse_done();

        // asynchronous reset mid-grant
        reset_dut();
        req = 16'h0100;
        tick();
        check("ar_vld_pre", {31'h0, grant_vld}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_vld", {31'h0, grant_vld}, 32'h0);
        check("ar_oh",  {16'h0, grant_oh},  32'h0);
        check("ar_to",  {31'h0, timeout},   32'h0);
        req = 16'h0006;
        #3;
        rst_n = 1'b1;
        tick();
        check("ar_first", {28'h0, grant_idx}, 32'h1);
        check("ar_first_oh", {16'h0, grant_oh}, 32'h0002);

        // randomized traffic against the model
        reset_dut();
        r = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: r = 16'($urandom);
                    1: r = 16'($urandom & $urandom & $urandom);
                    2: r = 16'h1 << $urandom_range(0, 15);
                    default: r = 16'h0;
                endcase
            end
            req  = r;
            done = ($urandom_range(0, 4) == 0);
            tick();
        end
        req  = 16'h0;
        done = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
